// File: rtl/fractal_sync_nd_rr_arbiter_if.sv
// Handshake bundle between sync-request pop-FIFOs and the per-dimension output slots of
// fractal_sync_nd_rr_arbiter. The master modport is the arbiter side.
interface fractal_sync_nd_rr_arbiter_if #(
    parameter int unsigned N_DIMS      = 2,
    parameter int unsigned IN_1D_PORTS = 2,
    parameter int unsigned IN_ND_PORTS = 1,
    parameter int unsigned OUT_PORTS   = 1,
    parameter int unsigned DATA_W      = 16
);
    logic [IN_ND_PORTS-1:0]                         nd_empty;
    logic [IN_ND_PORTS-1:0][DATA_W-1:0]             nd_element;
    logic [IN_ND_PORTS-1:0]                         nd_pop;
    logic [N_DIMS-1:0][IN_1D_PORTS-1:0]             d_empty;
    logic [N_DIMS-1:0][IN_1D_PORTS-1:0][DATA_W-1:0] d_element;
    logic [N_DIMS-1:0][IN_1D_PORTS-1:0]             d_pop;
    logic [N_DIMS-1:0][OUT_PORTS-1:0]               out_valid;
    logic [N_DIMS-1:0][OUT_PORTS-1:0][DATA_W-1:0]   out_element;
    logic [N_DIMS-1:0][OUT_PORTS-1:0]               out_ready;

    modport master (
        input  nd_empty, nd_element, d_empty, d_element, out_ready,
        output nd_pop, d_pop, out_valid, out_element
    );

    modport slave (
        output nd_empty, nd_element, d_empty, d_element, out_ready,
        input  nd_pop, d_pop, out_valid, out_element
    );
endinterface

// File: rtl/fractal_sync_nd_rr_arbiter.sv
// N-dimensional round-robin arbiter: ND requesters are granted atomically on every dimension
// first, then leftover slots per dimension go to that dimension's 1D requesters.
module fractal_sync_nd_rr_arbiter #(
    parameter int unsigned N_DIMS      = 2,
    parameter int unsigned IN_1D_PORTS = 2,
    parameter int unsigned IN_ND_PORTS = 1,
    parameter int unsigned OUT_PORTS   = 1,
    parameter int unsigned DATA_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    fractal_sync_nd_rr_arbiter_if.master  bus
);

    logic [N_DIMS-1:0][OUT_PORTS-1:0]             valid_q, valid_d, free;
    logic [N_DIMS-1:0][OUT_PORTS-1:0][DATA_W-1:0] elem_q, elem_d;
    logic [IN_ND_PORTS-1:0]                       nd_mask_q, nd_mask_d, nd_gnt;
    logic [N_DIMS-1:0][IN_1D_PORTS-1:0]           d_mask_q, d_mask_d, d_gnt;

    // A slot can be refilled in the same cycle its consumer takes it.
    assign free = ~valid_q | bus.out_ready;

    always_comb begin
        int                               f_cnt [N_DIMS];
        int                               nd_slots;
        int                               nd_cnt;
        int                               left;
        int                               cnt;
        logic                             done;
        logic [IN_ND_PORTS-1:0]           nd_p2;
        logic [IN_1D_PORTS-1:0]           p2;
        logic [N_DIMS-1:0][OUT_PORTS-1:0] taken;

        valid_d   = valid_q;
        elem_d    = elem_q;
        nd_mask_d = nd_mask_q;
        d_mask_d  = d_mask_q;
        nd_gnt    = '0;
        d_gnt     = '0;
        nd_p2     = '0;
        p2        = '0;
        taken     = '0;
        done      = 1'b0;
        nd_cnt    = 0;
        cnt       = 0;
        left      = 0;
        nd_slots  = OUT_PORTS;

        for (int d = 0; d < N_DIMS; d++) begin
            f_cnt[d] = 0;
            for (int o = 0; o < OUT_PORTS; o++) begin
                if (free[d][o]) begin
                    f_cnt[d]     = f_cnt[d] + 1;
                    valid_d[d][o] = 1'b0;
                    elem_d[d][o]  = '0;
                end
            end
            if (f_cnt[d] < nd_slots) nd_slots = f_cnt[d];
        end

        // ND arbiter: masked pass, then wrap pass while slots remain.
        for (int i = 0; i < IN_ND_PORTS; i++) begin
            if (!bus.nd_empty[i] && nd_mask_q[i] && nd_cnt < nd_slots) begin
                nd_gnt[i] = 1'b1;
                nd_cnt    = nd_cnt + 1;
            end
        end
        for (int i = 0; i < IN_ND_PORTS; i++) begin
            if (!bus.nd_empty[i] && !nd_gnt[i] && nd_cnt < nd_slots) begin
                nd_gnt[i] = 1'b1;
                nd_p2[i]  = 1'b1;
                nd_cnt    = nd_cnt + 1;
            end
        end
        if (nd_gnt != '0) begin
            nd_mask_d = (nd_p2 != '0) ? ~nd_p2 : (nd_mask_q & ~nd_gnt);
            if (nd_mask_d == '0) nd_mask_d = '1;
        end

        // Grant order (pass 1 ascending, then pass 2 ascending) picks lowest free slot.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < IN_ND_PORTS; i++) begin
                if (nd_gnt[i] && (nd_p2[i] == (pass == 1))) begin
                    for (int d = 0; d < N_DIMS; d++) begin
                        done = 1'b0;
                        for (int o = 0; o < OUT_PORTS; o++) begin
                            if (!done && free[d][o] && !taken[d][o]) begin
                                taken[d][o]   = 1'b1;
                                valid_d[d][o] = 1'b1;
                                elem_d[d][o]  = bus.nd_element[i];
                                done          = 1'b1;
                            end
                        end
                    end
                end
            end
        end

        for (int d = 0; d < N_DIMS; d++) begin
            left = f_cnt[d] - nd_cnt;
            cnt  = 0;
            p2   = '0;
            for (int i = 0; i < IN_1D_PORTS; i++) begin
                if (!bus.d_empty[d][i] && d_mask_q[d][i] && cnt < left) begin
                    d_gnt[d][i] = 1'b1;
                    cnt         = cnt + 1;
                end
            end
            for (int i = 0; i < IN_1D_PORTS; i++) begin
                if (!bus.d_empty[d][i] && !d_gnt[d][i] && cnt < left) begin
                    d_gnt[d][i] = 1'b1;
                    p2[i]       = 1'b1;
                    cnt         = cnt + 1;
                end
            end
            if (d_gnt[d] != '0) begin
                d_mask_d[d] = (p2 != '0) ? ~p2 : (d_mask_q[d] & ~d_gnt[d]);
                if (d_mask_d[d] == '0) d_mask_d[d] = '1;
            end
            for (int pass = 0; pass < 2; pass++) begin
                for (int i = 0; i < IN_1D_PORTS; i++) begin
                    if (d_gnt[d][i] && (p2[i] == (pass == 1))) begin
                        done = 1'b0;
                        for (int o = 0; o < OUT_PORTS; o++) begin
                            if (!done && free[d][o] && !taken[d][o]) begin
                                taken[d][o]   = 1'b1;
                                valid_d[d][o] = 1'b1;
                                elem_d[d][o]  = bus.d_element[d][i];
                                done          = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= '0;
            elem_q    <= '0;
            nd_mask_q <= '1;
            d_mask_q  <= '1;
        end else begin
            valid_q   <= valid_d;
            elem_q    <= elem_d;
            nd_mask_q <= nd_mask_d;
            d_mask_q  <= d_mask_d;
        end
    end

    assign bus.nd_pop      = rst_i ? '0 : nd_gnt;
    assign bus.d_pop       = rst_i ? '0 : d_gnt;
    assign bus.out_valid   = valid_q;
    assign bus.out_element = elem_q;

endmodule

// File: tb/tb_fractal_sync_nd_rr_arbiter.sv
// Directed bench: per-cycle vector table on a 2-dim/1-slot arbiter, plus a hand-written
// wrap-around sequence on a 3-port/2-slot instance.
module tb_fractal_sync_nd_rr_arbiter;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fractal_sync_nd_rr_arbiter_if #(.N_DIMS(2), .IN_1D_PORTS(2), .IN_ND_PORTS(1),
                                    .OUT_PORTS(1), .DATA_W(16)) bus_a ();
    fractal_sync_nd_rr_arbiter_if #(.N_DIMS(2), .IN_1D_PORTS(3), .IN_ND_PORTS(1),
                                    .OUT_PORTS(2), .DATA_W(16)) bus_b ();

    fractal_sync_nd_rr_arbiter #(.N_DIMS(2), .IN_1D_PORTS(2), .IN_ND_PORTS(1),
                                 .OUT_PORTS(1), .DATA_W(16)) u_dut_a (
        .clk_i (clk),
        .rst_i (rst_a),
        .bus   (bus_a)
    );

    fractal_sync_nd_rr_arbiter #(.N_DIMS(2), .IN_1D_PORTS(3), .IN_ND_PORTS(1),
                                 .OUT_PORTS(2), .DATA_W(16)) u_dut_b (
        .clk_i (clk),
        .rst_i (rst_b),
        .bus   (bus_b)
    );

    // d_empty/d_pop bits: [3]=dim1 p1, [2]=dim1 p0, [1]=dim0 p1, [0]=dim0 p0.
    // ready/valid bits: [1]=dim1 slot, [0]=dim0 slot.
    typedef struct packed {
        logic        rst;
        logic        nd_empty;
        logic [15:0] nd_elem;
        logic [3:0]  d_empty;
        logic [1:0]  ready;
        logic        nd_pop;
        logic [3:0]  d_pop;
        logic [1:0]  valid;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic nd_empty, logic [15:0] nd_elem,
                                logic [3:0] d_empty, logic [1:0] ready, logic nd_pop,
                                logic [3:0] d_pop, logic [1:0] valid,
                                logic [15:0] e0, logic [15:0] e1);
        vec_t v;
        v.rst = rst;       v.nd_empty = nd_empty; v.nd_elem = nd_elem;
        v.d_empty = d_empty; v.ready = ready;     v.nd_pop = nd_pop;
        v.d_pop = d_pop;   v.valid = valid;       v.e0 = e0;  v.e1 = e1;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive_a(input vec_t v);
        rst_a               = v.rst;
        bus_a.nd_empty      = v.nd_empty;
        bus_a.nd_element[0] = v.nd_elem;
        bus_a.d_empty       = v.d_empty;
        bus_a.out_ready     = v.ready;
    endtask

    initial begin
        logic [2:0]  exp_pop_b [4];
        logic [1:0]  exp_v_b   [4];
        logic [15:0] exp_s0_b  [4];
        logic [15:0] exp_s1_b  [4];

        // Reset with everything non-empty.
        vecs.push_back(mk(1, 0, 16'h0011, 4'b0000, 2'b11, 0, 4'b0000, 2'b00, 16'h0, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0011, 4'b0000, 2'b11, 0, 4'b0000, 2'b00, 16'h0, 16'h0));
        // Dim0 ports 0,1 alternate; output follows one cycle later.
        vecs.push_back(mk(0, 1, 16'h0, 4'b1100, 2'b11, 0, 4'b0001, 2'b00, 16'h0,    16'h0));
        vecs.push_back(mk(0, 1, 16'h0, 4'b1100, 2'b11, 0, 4'b0010, 2'b01, 16'h1000, 16'h0));
        vecs.push_back(mk(0, 1, 16'h0, 4'b1100, 2'b11, 0, 4'b0001, 2'b01, 16'h1001, 16'h0));
        vecs.push_back(mk(0, 1, 16'h0, 4'b1100, 2'b11, 0, 4'b0010, 2'b01, 16'h1000, 16'h0));
        // Fill dim1 slot as well.
        vecs.push_back(mk(0, 1, 16'h0, 4'b1000, 2'b11, 0, 4'b0101, 2'b01, 16'h1001, 16'h0));
        // ND blocked by stalled dim1 slot; dim0 1D still served.
        vecs.push_back(mk(0, 0, 16'h00A5, 4'b1100, 2'b01, 0, 4'b0010, 2'b11, 16'h1000, 16'h2000));
        // Dim1 ready: ND popped atomically, dim0 1D loses its slot.
        vecs.push_back(mk(0, 0, 16'h00A5, 4'b1100, 2'b11, 1, 4'b0000, 2'b11, 16'h1001, 16'h2000));
        // Both dims show 0xA5; then dim0 stalls for 5 cycles.
        vecs.push_back(mk(0, 1, 16'h0, 4'b1100, 2'b10, 0, 4'b0000, 2'b11, 16'h00A5, 16'h00A5));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0, 1, 16'h0, 4'b1100, 2'b10, 0, 4'b0000, 2'b01, 16'h00A5, 16'h0));
        // Ready returns: pass-through refill keeps valid high.
        vecs.push_back(mk(0, 1, 16'h0, 4'b1100, 2'b11, 0, 4'b0001, 2'b01, 16'h00A5, 16'h0));
        vecs.push_back(mk(0, 1, 16'h0, 4'b1100, 2'b11, 0, 4'b0010, 2'b01, 16'h1000, 16'h0));
        vecs.push_back(mk(0, 1, 16'h0, 4'b1100, 2'b11, 0, 4'b0001, 2'b01, 16'h1001, 16'h0));
        // Mid-stream reset (mask was pointing at port 1), then restart from port 0.
        vecs.push_back(mk(1, 1, 16'h0, 4'b1100, 2'b11, 0, 4'b0000, 2'b00, 16'h0,    16'h0));
        vecs.push_back(mk(0, 1, 16'h0, 4'b1100, 2'b11, 0, 4'b0001, 2'b00, 16'h0,    16'h0));
        vecs.push_back(mk(0, 1, 16'h0, 4'b1100, 2'b11, 0, 4'b0010, 2'b01, 16'h1000, 16'h0));

        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
                bus_a.d_element[d][p] = 16'(16'h1000 * (d + 1) + p);
        drive_a(vecs[0]);

        rst_b               = 1'b1;
        bus_b.nd_empty      = 1'b1;
        bus_b.nd_element[0] = 16'h00EE;
        bus_b.d_empty       = 6'b111_000;
        bus_b.out_ready     = '1;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 3; p++)
                bus_b.d_element[d][p] = 16'(16'h1000 * (d + 1) + p);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive_a(vecs[i]);
            #1;
            chk("nd_pop",   i, 32'(bus_a.nd_pop),         32'(vecs[i].nd_pop));
            chk("d_pop",    i, 32'(bus_a.d_pop),          32'(vecs[i].d_pop));
            chk("valid",    i, 32'(bus_a.out_valid),      32'(vecs[i].valid));
            chk("elem_d0",  i, 32'(bus_a.out_element[0]), 32'(vecs[i].e0));
            chk("elem_d1",  i, 32'(bus_a.out_element[1]), 32'(vecs[i].e1));
        end

        // Wrap-around on 3 ports sharing 2 slots: {0,1}, {2,0}, {1,2}, {0,1}.
        exp_pop_b = '{3'b011, 3'b101, 3'b110, 3'b011};
        exp_v_b   = '{2'b00, 2'b11, 2'b11, 2'b11};
        exp_s0_b  = '{16'h0, 16'h1000, 16'h1002, 16'h1001};
        exp_s1_b  = '{16'h0, 16'h1001, 16'h1000, 16'h1002};

        @(negedge clk);
        #1;
        chk("b_rst_pop",   0, 32'(bus_b.d_pop),     32'h0);
        chk("b_rst_valid", 0, 32'(bus_b.out_valid), 32'h0);
        rst_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("b_d_pop",  i, 32'(bus_b.d_pop),             {26'h0, 3'b000, exp_pop_b[i]});
            chk("b_valid0", i, 32'(bus_b.out_valid[0]),      32'(exp_v_b[i]));
            chk("b_valid1", i, 32'(bus_b.out_valid[1]),      32'h0);
            chk("b_slot0",  i, 32'(bus_b.out_element[0][0]), 32'(exp_s0_b[i]));
            chk("b_slot1",  i, 32'(bus_b.out_element[0][1]), 32'(exp_s1_b[i]));
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
